// File: rtl/uram_sdp_pipe_if.sv
// Bus bundle for uram_sdp_pipe: port A (byte-masked write) and port B (pipelined read).
// The DMA writer / GEMM reader side uses master; the buffer uses slave.
interface uram_sdp_pipe_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4096
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NB = WIDTH / 8;

    logic             enA;
    logic             weA;
    logic [NB-1:0]    beA;
    logic [AW-1:0]    addrA;
    logic [WIDTH-1:0] dinA;
    logic             enB;
    logic [AW-1:0]    addrB;
    logic [WIDTH-1:0] doutB;
    logic             validB;

    modport master (
        output enA, weA, beA, addrA, dinA, enB, addrB,
        input  doutB, validB
    );

    modport slave (
        input  enA, weA, beA, addrA, dinA, enB, addrB,
        output doutB, validB
    );
endinterface

// File: rtl/uram_sdp_pipe.sv
// Simple-dual-port UltraRAM buffer: byte-masked writes on A, READ_LATENCY-deep read pipe on B.
// Define URAM_BYPASS_EN for write-first forwarding on same-address collisions.
module uram_sdp_pipe #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned READ_LATENCY = 3
) (
    input logic            clkA,
    input logic            rst,
    uram_sdp_pipe_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NB = WIDTH / 8;

`ifndef SYNTHESIS
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
`else
    logic [WIDTH-1:0] mem [DEPTH];
`endif

    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_fire;
    logic [WIDTH-1:0] rd_word;
    logic             vld_q  [READ_LATENCY];
    logic [WIDTH-1:0] data_q [READ_LATENCY];

    // A power-of-two depth covers the whole address space, so no compare is needed.
    if (DEPTH == (2 ** AW)) begin : g_full_range
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_part_range
        localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);
        assign wr_in_range = ({1'b0, bus.addrA} < DepthW);
        assign rd_in_range = ({1'b0, bus.addrB} < DepthW);
    end

    assign wr_fire = !rst && bus.enA && bus.weA && wr_in_range;

    always_ff @(posedge clkA) begin
        if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.beA[i]) begin
                    mem[bus.addrA][8*i +: 8] <= bus.dinA[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.addrB];
`ifdef URAM_BYPASS_EN
            // Write-first: merge the enabled lanes of the concurrent write.
            if (wr_fire && (bus.addrA == bus.addrB)) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.beA[i]) begin
                        rd_word[8*i +: 8] = bus.dinA[8*i +: 8];
                    end
                end
            end
`endif
        end
    end

    // Data registers load only behind a valid bit so doutB holds between strobes.
    always_ff @(posedge clkA) begin
        if (rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                vld_q[k]  <= 1'b0;
                data_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= bus.enB;
            if (bus.enB) begin
                data_q[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign bus.doutB  = data_q[READ_LATENCY-1];
    assign bus.validB = vld_q[READ_LATENCY-1];
endmodule
